i2c_config_sequencer: RTL and testbench
=======================================

Name: i2c_config_sequencer

Overview:
- Parametrised I2C register-initialisation sequencer for codec/peripheral bring-up, e.g. the WM8731 audio codec at 7'h1A.
- Drives the existing i2c_master through its start/done/error handshake.
- Walks an external combinational command table of NUM_CMDS entries and writes each entry.
- Adds bounded per-command retry, a done-wait timeout, a re-triggerable start, and sticky completion/failure status.

Parameters:
- NUM_CMDS, 10: number of table entries sent, indices 0..NUM_CMDS-1.
- CMD_W, 16: width of one table entry (register address plus data).
- DEV_ADDR, 7'h1A: 7-bit I2C device address.
- MAX_RETRIES, 3: retries allowed per command after its first attempt.
- TIMEOUT_CYCLES, 4000: WAIT cycles allowed before an attempt is treated as an error.

Ports:
- clk, in, 1: i2c-domain clock. Single clock.
- reset, in, 1: synchronous, active-high reset.
- go, in, 1: single-cycle request to start or restart the sequence. Ignored while busy.
- cmd_index, out, IW=max(1,$clog2(NUM_CMDS)): table index currently addressed.
- cmd_data, in, CMD_W: table entry for cmd_index. Combinational, zero latency.
- i2c_data, out, CMD_W+8: frame sent to the master, {DEV_ADDR, 1'b0, cmd_data}.
- i2c_start, out, 1: one-cycle start pulse to the master.
- i2c_done, in, 1: master finished the frame.
- i2c_error, in, 1: master reports NACK/error. Valid when i2c_done=1.
- busy, out, 1: high in LOAD, WAIT and NEXT.
- cfg_done, out, 1: sticky; all commands acknowledged.
- cfg_error, out, 1: sticky; a command exhausted its retries.
- fail_index, out, IW: index of the failing command. Valid while cfg_error=1.

Behaviour:
- Reset values:
  - State IDLE.
  - cmd_index, i2c_data, i2c_start, busy, cfg_done, cfg_error, fail_index all 0.
  - Retry and timeout counters 0.
  - Reset mid-transfer aborts immediately; no further i2c_start is issued.
- States: IDLE, LOAD, WAIT, NEXT, DONE, FAIL.
- IDLE / DONE / FAIL, on go=1:
  - cmd_index<=0, retry_cnt<=0, cfg_done<=0, cfg_error<=0.
  - Next state LOAD.
- LOAD (1 cycle):
  - i2c_data<={DEV_ADDR,1'b0,cmd_data}.
  - i2c_start<=1.
  - timeout_cnt<=0.
  - Next state WAIT.
  - i2c_data holds steady until the next LOAD.
- WAIT:
  - i2c_start<=0, so the start pulse is exactly 1 cycle wide.
  - i2c_done is ignored on the first WAIT cycle (stale-done blanking).
  - From the second cycle, done with error=0 goes to NEXT.
  - done with error=1, or timeout_cnt reaching TIMEOUT_CYCLES-1 with no done, counts as a failed attempt:
    - If retry_cnt<MAX_RETRIES: retry_cnt++, go to LOAD with the same cmd_index.
    - Otherwise: fail_index<=cmd_index, cfg_error<=1, go to FAIL.
  - If done and timeout expiry coincide, done wins.
- NEXT (1 cycle):
  - retry_cnt<=0.
  - If cmd_index==NUM_CMDS-1: cfg_done<=1, go to DONE. cmd_index is not incremented; no wrap-around.
  - Otherwise: cmd_index++, go to LOAD.
- DONE / FAIL:
  - busy=0.
  - Status holds until go or reset.
- go asserted in LOAD, WAIT or NEXT is dropped, not queued.
- Counter widths:
  - retry_cnt is $clog2(MAX_RETRIES+1) bits; MAX_RETRIES=0 means a single attempt.
  - timeout_cnt is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
- Minimum latency for one command: 1 (LOAD) + k WAIT cycles + 1 (NEXT), where k≥2.

Optional Feature:
- Macro: I2C_SEQ_AUTOSTART_EN.
- Defined: the sequencer behaves as if go=1 on the first cycle after reset deasserts, so the sequence runs once automatically at power-up. Later runs still need go.
- Undefined: the sequencer stays in IDLE after reset until go is asserted.

Test Plan:
- NUM_CMDS=10, table entry i={7'(i),9'(i+1)}; bench master acks every frame after 5 cycles; pulse go → exactly 10 i2c_start pulses. Frame 0 is 24'h340001. cfg_done=1 after the 10th done; busy=0; cfg_error=0.
- Master NACKs index 3 twice, then acks → index 3 is sent 3 times, indices 4..9 follow, cfg_done=1.
- Master NACKs index 5 on every attempt, MAX_RETRIES=3 → exactly 4 starts at index 5, cfg_error=1, fail_index=5, no start for index 6. A later go restarts from index 0 with status cleared.
- Master never raises done on index 0, TIMEOUT_CYCLES=20 → retry every 20 WAIT cycles; FAIL after 4 attempts, fail_index=0.
- go pulsed in WAIT → ignored. Stale i2c_done=1 held on the first WAIT cycle → not counted. reset asserted mid-WAIT → all outputs 0 on the next edge, no further starts.
- Build with I2C_SEQ_AUTOSTART_EN, never pulse go → the sequence starts one cycle after reset deasserts and reaches cfg_done. Build without the macro → stays in IDLE and no starts are issued.

Source files
------------

// File: rtl/i2c_config_sequencer_if.sv
// Frame handshake between the config sequencer and the i2c master.
// Sequencer owns data/start; the master answers with done/error.
interface i2c_config_sequencer_if #(
  parameter int CMD_W = 16
) ();
  logic [CMD_W+7:0] i2c_data;
  logic             i2c_start;
  logic             i2c_done;
  logic             i2c_error;

  modport master (
    output i2c_data,
    output i2c_start,
    input  i2c_done,
    input  i2c_error
  );

  modport slave (
    input  i2c_data,
    input  i2c_start,
    output i2c_done,
    output i2c_error
  );
endinterface

// File: rtl/i2c_config_sequencer.sv
// I2C register-init sequencer: walks a command table with retry/timeout.
// Optional I2C_SEQ_AUTOSTART_EN runs the sequence once after reset.
module i2c_config_sequencer #(
  parameter int         NUM_CMDS       = 10,
  parameter int         CMD_W          = 16,
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         MAX_RETRIES    = 3,
  parameter int         TIMEOUT_CYCLES = 4000,
  localparam int        IW = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  output logic [IW-1:0]          cmd_index,
  input  logic [CMD_W-1:0]       cmd_data,
  i2c_config_sequencer_if.master bus,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   cfg_error,
  output logic [IW-1:0]          fail_index
);

  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST   = IW'(NUM_CMDS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT, NEXT, DONE, FAIL
  } state_t;

  state_t        state;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] timeout_cnt;
  logic          go_eff;
  logic          first;
  logic          ack;
  logic          nack;

`ifdef I2C_SEQ_AUTOSTART_EN
  logic auto;

  always_ff @(posedge clk) begin
    if (reset) auto <= 1'b1;
    else       auto <= 1'b0;
  end

  assign go_eff = go | auto;
`else
  assign go_eff = go;
`endif

  // First WAIT cycle blanks a done left over from the previous frame
  assign first = (timeout_cnt == '0);
  assign ack   = !first && bus.i2c_done && !bus.i2c_error;
  assign nack  = (!first && bus.i2c_done) || (timeout_cnt == T_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_index     <= '0;
      bus.i2c_data  <= '0;
      bus.i2c_start <= 1'b0;
      busy          <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_error     <= 1'b0;
      fail_index    <= '0;
      retry_cnt     <= '0;
      timeout_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, FAIL: begin
          if (go_eff) begin
            cmd_index <= '0;
            retry_cnt <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          bus.i2c_data  <= {DEV_ADDR, 1'b0, cmd_data};
          bus.i2c_start <= 1'b1;
          timeout_cnt   <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          bus.i2c_start <= 1'b0;
          if (timeout_cnt != T_SAT)
            timeout_cnt <= timeout_cnt + 1'b1;
          // A clean ack wins over a coincident timeout
          if (ack) begin
            state <= NEXT;
          end else if (nack) begin
            if (retry_cnt < R_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= LOAD;
            end else begin
              fail_index <= cmd_index;
              cfg_error  <= 1'b1;
              busy       <= 1'b0;
              state      <= FAIL;
            end
          end
        end
        NEXT: begin
          retry_cnt <= '0;
          if (cmd_index == LAST) begin
            cfg_done <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            cmd_index <= cmd_index + 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer with a scripted i2c master.
// Covers ack, NACK retry, failure, timeout, blanking, go drop and reset.
module tb_i2c_config_sequencer;

  localparam int NUM_CMDS = 10;
  localparam int CMD_W    = 16;
  localparam int IW       = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [IW-1:0] cmd_index;
  logic [IW-1:0] fail_index;
  logic [15:0]   cmd_data;
  logic          busy;
  logic          cfg_done;
  logic          cfg_error;

  logic rsp_done = 1'b0;
  logic rsp_err  = 1'b0;
  logic man_done = 1'b0;

  bit resp_en    = 1'b1;
  int nack_idx   = -1;
  int nack_max   = 0;
  int silent_idx = -1;
  int log_base   = 0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wide_cnt = 0;
  bit prev_start = 1'b0;

  int          st_idx[$];
  logic [23:0] st_data[$];
  int          st_cyc[$];

  i2c_config_sequencer_if #(.CMD_W(CMD_W)) bus ();

  assign bus.i2c_done  = rsp_done | man_done;
  assign bus.i2c_error = rsp_err;
  assign cmd_data = {3'b000, cmd_index, 9'(cmd_index) + 9'd1};

  i2c_config_sequencer #(
    .NUM_CMDS(NUM_CMDS),
    .CMD_W(CMD_W),
    .DEV_ADDR(7'h1A),
    .MAX_RETRIES(3),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .cmd_index(cmd_index),
    .cmd_data(cmd_data),
    .bus(bus),
    .busy(busy),
    .cfg_done(cfg_done),
    .cfg_error(cfg_error),
    .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.i2c_start) begin
      st_idx.push_back(int'(cmd_index));
      st_data.push_back(bus.i2c_data);
      st_cyc.push_back(cyc);
      if (prev_start) wide_cnt <= wide_cnt + 1;
    end
    prev_start <= bus.i2c_start;
  end

  function automatic int count_idx(input int from, input int v);
    int n = 0;
    for (int i = from; i < st_idx.size(); i++)
      if (st_idx[i] == v) n++;
    return n;
  endfunction

  // Scripted master: acks ~5 cycles after each start unless told otherwise
  initial begin
    int  ridx;
    bit  rerr;
    forever begin
      @(posedge clk); #1;
      if (bus.i2c_start && resp_en && !reset) begin
        ridx = int'(cmd_index);
        if (ridx != silent_idx) begin
          rerr = (ridx == nack_idx) && (count_idx(log_base, ridx) < nack_max);
          repeat (4) @(posedge clk);
          #1;
          rsp_done = 1'b1;
          rsp_err  = rerr;
          @(posedge clk); #1;
          rsp_done = 1'b0;
          rsp_err  = 1'b0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_go;
    tick;
    go = 1'b1;
    tick;
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic wait_start(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.i2c_start && int'(cmd_index) == idx) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    repeat (3) tick;
    total++;
    if ({busy, cfg_done, cfg_error, bus.i2c_start} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got %b want 0000",
               {busy, cfg_done, cfg_error, bus.i2c_start});
    end
    total++;
    if ({cmd_index, fail_index, bus.i2c_data} !== 32'h0) begin
      bad++;
      $display("FAIL reset_regs got %h want 0",
               {cmd_index, fail_index, bus.i2c_data});
    end
    reset = 1'b0;
  endtask

  task automatic test_power_up;
    bit ok;
`ifdef I2C_SEQ_AUTOSTART_EN
    tick;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL autostart_busy got %b want 1", busy);
    end
    wait_idle(2000, ok);
    total++;
    if (!ok || cfg_done !== 1'b1 || st_idx.size() != NUM_CMDS) begin
      bad++;
      $display("FAIL autostart_run got ok=%0d done=%b starts=%0d want 1 1 %0d",
               ok, cfg_done, st_idx.size(), NUM_CMDS);
    end
`else
    repeat (30) tick;
    total++;
    if (st_idx.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got starts=%0d busy=%b want 0 0",
               st_idx.size(), busy);
    end
`endif
  endtask

  task automatic test_normal;
    bit ok;
    int n;
    int errs;
    logic [23:0] exp;
    log_base = st_idx.size();
    pulse_go;
    wait_idle(1000, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL normal_timeout got busy=%b want 0", busy);
    end
    n = st_idx.size() - log_base;
    total++;
    if (n != NUM_CMDS) begin
      bad++;
      $display("FAIL normal_starts got %0d want %0d", n, NUM_CMDS);
    end
    total++;
    if (n < 1 || st_data[log_base] !== 24'h340001) begin
      bad++;
      $display("FAIL frame0 got %h want 340001",
               (n < 1) ? 24'h0 : st_data[log_base]);
    end
    errs = 0;
    for (int i = 0; i < n && i < NUM_CMDS; i++) begin
      exp = {7'h1A, 1'b0, 3'b000, 4'(i), 9'(i + 1)};
      if (st_idx[log_base+i] != i || st_data[log_base+i] !== exp) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL normal_frames got %0d bad frames want 0", errs);
    end
    total++;
    if ({cfg_done, cfg_error, busy} !== 3'b100) begin
      bad++;
      $display("FAIL normal_status got %b want 100", {cfg_done, cfg_error, busy});
    end
    total++;
    if (cmd_index !== 4'd9) begin
      bad++;
      $display("FAIL no_wrap got %0d want 9", cmd_index);
    end
    total++;
    if (wide_cnt != 0) begin
      bad++;
      $display("FAIL start_width got %0d wide pulses want 0", wide_cnt);
    end
  endtask

  task automatic test_nack_retry;
    bit ok;
    int n;
    int errs;
    int exp_seq[$];
    log_base = st_idx.size();
    nack_idx = 3;
    nack_max = 2;
    pulse_go;
    wait_idle(1000, ok);
    for (int i = 0; i < NUM_CMDS; i++) begin
      exp_seq.push_back(i);
      if (i == 3) begin
        exp_seq.push_back(3);
        exp_seq.push_back(3);
      end
    end
    n = st_idx.size() - log_base;
    errs = (n == exp_seq.size()) ? 0 : 1;
    for (int i = 0; i < n && i < exp_seq.size(); i++)
      if (st_idx[log_base+i] != exp_seq[i]) errs++;
    total++;
    if (!ok || errs != 0) begin
      bad++;
      $display("FAIL nack_retry_seq got ok=%0d starts=%0d errs=%0d want 1 12 0",
               ok, n, errs);
    end
    total++;
    if ({cfg_done, cfg_error} !== 2'b10) begin
      bad++;
      $display("FAIL nack_retry_status got %b want 10", {cfg_done, cfg_error});
    end
    nack_idx = -1;
  endtask

  task automatic test_fail;
    bit ok;
    int n;
    log_base = st_idx.size();
    nack_idx = 5;
    nack_max = 1000;
    pulse_go;
    wait_idle(1000, ok);
    n = st_idx.size() - log_base;
    total++;
    if (!ok || n != 9 || count_idx(log_base, 5) != 4 || count_idx(log_base, 6) != 0) begin
      bad++;
      $display("FAIL fail_starts got ok=%0d n=%0d idx5=%0d idx6=%0d want 1 9 4 0",
               ok, n, count_idx(log_base, 5), count_idx(log_base, 6));
    end
    total++;
    if ({cfg_done, cfg_error, busy} !== 3'b010 || fail_index !== 4'd5) begin
      bad++;
      $display("FAIL fail_status got flags=%b idx=%0d want 010 5",
               {cfg_done, cfg_error, busy}, fail_index);
    end
    nack_idx = -1;
    log_base = st_idx.size();
    pulse_go;
    total++;
    if ({cfg_error, busy} !== 2'b01 || cmd_index !== 4'd0) begin
      bad++;
      $display("FAIL restart_clear got err_busy=%b idx=%0d want 01 0",
               {cfg_error, busy}, cmd_index);
    end
    wait_idle(1000, ok);
    total++;
    if (!ok || cfg_done !== 1'b1 || st_idx.size() - log_base != NUM_CMDS) begin
      bad++;
      $display("FAIL restart_run got ok=%0d done=%b starts=%0d want 1 1 10",
               ok, cfg_done, st_idx.size() - log_base);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    int gap;
    log_base = st_idx.size();
    silent_idx = 0;
    pulse_go;
    wait_idle(500, ok);
    n = st_idx.size() - log_base;
    gap = (n >= 2) ? st_cyc[log_base+1] - st_cyc[log_base] : -1;
    total++;
    if (!ok || n != 4 || count_idx(log_base, 0) != 4) begin
      bad++;
      $display("FAIL timeout_starts got ok=%0d n=%0d want 1 4", ok, n);
    end
    total++;
    if (gap != 21) begin
      bad++;
      $display("FAIL timeout_gap got %0d want 21", gap);
    end
    total++;
    if (cfg_error !== 1'b1 || fail_index !== 4'd0) begin
      bad++;
      $display("FAIL timeout_status got err=%b idx=%0d want 1 0",
               cfg_error, fail_index);
    end
    silent_idx = -1;
  endtask

  task automatic test_go_in_wait;
    bit ok;
    log_base = st_idx.size();
    pulse_go;
    wait_start(4, 300, ok);
    tick;
    go = 1'b1;
    tick;
    go = 1'b0;
    total++;
    if (!ok || cmd_index !== 4'd4 || busy !== 1'b1) begin
      bad++;
      $display("FAIL go_dropped got ok=%0d idx=%0d busy=%b want 1 4 1",
               ok, cmd_index, busy);
    end
    wait_idle(1000, ok);
    total++;
    if (!ok || cfg_done !== 1'b1 || st_idx.size() - log_base != NUM_CMDS) begin
      bad++;
      $display("FAIL go_dropped_run got ok=%0d done=%b starts=%0d want 1 1 10",
               ok, cfg_done, st_idx.size() - log_base);
    end
  endtask

  task automatic test_stale_done;
    bit ok;
    log_base = st_idx.size();
    resp_en = 1'b0;
    pulse_go;
    wait_start(0, 50, ok);
    man_done = 1'b1;
    tick;
    man_done = 1'b0;
    repeat (3) tick;
    total++;
    if (!ok || cmd_index !== 4'd0 || busy !== 1'b1 || st_idx.size() - log_base != 1) begin
      bad++;
      $display("FAIL stale_done got ok=%0d idx=%0d busy=%b starts=%0d want 1 0 1 1",
               ok, cmd_index, busy, st_idx.size() - log_base);
    end
    man_done = 1'b1;
    tick;
    man_done = 1'b0;
    resp_en = 1'b1;
    wait_idle(1000, ok);
    total++;
    if (!ok || cfg_done !== 1'b1 || st_idx.size() - log_base != NUM_CMDS) begin
      bad++;
      $display("FAIL stale_done_run got ok=%0d done=%b starts=%0d want 1 1 10",
               ok, cfg_done, st_idx.size() - log_base);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n0;
    pulse_go;
    wait_start(2, 300, ok);
    tick;
    tick;
    reset = 1'b1;
    tick;
    total++;
    if (!ok || {busy, cfg_done, cfg_error, bus.i2c_start} !== 4'b0 ||
        {cmd_index, fail_index, bus.i2c_data} !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid got ok=%0d flags=%b regs=%h want 1 0000 0", ok,
               {busy, cfg_done, cfg_error, bus.i2c_start},
               {cmd_index, fail_index, bus.i2c_data});
    end
    n0 = st_idx.size();
    repeat (10) tick;
    total++;
    if (st_idx.size() != n0) begin
      bad++;
      $display("FAIL reset_hold_starts got %0d want %0d", st_idx.size(), n0);
    end
    reset = 1'b0;
`ifdef I2C_SEQ_AUTOSTART_EN
    tick;
    wait_idle(1000, ok);
    total++;
    if (!ok || cfg_done !== 1'b1 || st_idx.size() - n0 != NUM_CMDS) begin
      bad++;
      $display("FAIL reset_autostart got ok=%0d done=%b starts=%0d want 1 1 10",
               ok, cfg_done, st_idx.size() - n0);
    end
`else
    repeat (30) tick;
    total++;
    if (st_idx.size() != n0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got starts=%0d busy=%b want %0d 0",
               st_idx.size(), busy, n0);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_power_up;
    test_normal;
    test_nack_retry;
    test_fail;
    test_timeout;
    test_go_in_wait;
    test_stale_done;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
